// File: rtl/pwm_compare_channel.sv
// pwm_compare_channel
// -------------------
// Turns the shared free-running counter value into one PWM output channel.
// The compare value and the output polarity are double-buffered. CPU writes
// land in a shadow register. The active register takes the shadow only at a
// period boundary, which is the transition of the counter into 0. The output
// therefore never changes duty or polarity part-way through a period.
//
// Optional feature: define PWM_DEADTIME_EN to insert a programmable dead-time
// gap between pwm_out and pwm_out_n. During the gap both outputs sit at the
// inactive level. Without the macro, dead_time is ignored and pwm_out_n is
// the registered inverse of pwm_out.
//
// Parameters:
//   WIDTH           width of counter_value and the compare registers
//   DEADTIME_WIDTH  width of the dead-time down-counter
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   enable          channel enable; 0 forces the idle (inactive) level
//   counter_value   registered value from the upstream counter (up or down)
//   cfg_write       one-cycle strobe capturing cfg_compare / cfg_polarity
//   cfg_compare     new compare (duty) value
//   cfg_polarity    0 = active-high output, 1 = active-low output
//   dead_time       dead-time length in clk cycles (PWM_DEADTIME_EN only)
//   pwm_out         PWM output
//   pwm_out_n       complementary output
//   match_pulse     one-cycle strobe when the counter reaches the compare value
//   period_pulse    one-cycle strobe at each period boundary
//   update_pending  shadow holds a value not yet applied
module pwm_compare_channel #(
  parameter int WIDTH          = 8,
  parameter int DEADTIME_WIDTH = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      enable,
  input  logic [WIDTH-1:0]          counter_value,
  input  logic                      cfg_write,
  input  logic [WIDTH-1:0]          cfg_compare,
  input  logic                      cfg_polarity,
  input  logic [DEADTIME_WIDTH-1:0] dead_time,
  output logic                      pwm_out,
  output logic                      pwm_out_n,
  output logic                      match_pulse,
  output logic                      period_pulse,
  output logic                      update_pending
);

  localparam logic [WIDTH-1:0] ZERO = {WIDTH{1'b0}};

  logic [WIDTH-1:0] prev_value;
  logic             prev_valid;
  logic [WIDTH-1:0] shadow_compare;
  logic [WIDTH-1:0] active_compare;
  logic             shadow_polarity;
  logic             active_polarity;

  logic             period_start;
  logic             level;
  logic             match_now;
  logic             load_active;
  logic             out_next;
  logic             out_n_next;

  // Boundary, raw level and match decode from the current and previous counter value.
  always_comb begin
    // prev_valid low means "no history", so a counter sitting at 0 when the
    // channel comes up still produces one boundary, and a halted counter
    // produces no more than one.
    period_start = enable & (counter_value == ZERO)
                 & (~prev_valid | (prev_value != ZERO));
    level        = (counter_value < active_compare);
    match_now    = enable & (counter_value == active_compare)
                 & (~prev_valid | (prev_value != counter_value));
    load_active  = period_start & update_pending;
  end

  // Counter history used for edge-style boundary and match detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_value <= ZERO;
      prev_valid <= 1'b0;
    end else begin
      prev_value <= counter_value;
      prev_valid <= enable;
    end
  end

  // Shadow/active double buffer for compare value and polarity.
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_compare  <= ZERO;
      shadow_polarity <= 1'b0;
      active_compare  <= ZERO;
      active_polarity <= 1'b0;
      update_pending  <= 1'b0;
    end else if (cfg_write && !enable) begin
      // Channel idle: nothing to glitch, so apply the write immediately.
      shadow_compare  <= cfg_compare;
      shadow_polarity <= cfg_polarity;
      active_compare  <= cfg_compare;
      active_polarity <= cfg_polarity;
      update_pending  <= 1'b0;
    end else begin
      // When a write coincides with the boundary, the old shadow goes active
      // and the new write stays pending for the following boundary.
      if (load_active) begin
        active_compare  <= shadow_compare;
        active_polarity <= shadow_polarity;
      end
      if (cfg_write) begin
        shadow_compare  <= cfg_compare;
        shadow_polarity <= cfg_polarity;
        update_pending  <= 1'b1;
      end else if (load_active) begin
        update_pending  <= 1'b0;
      end
    end
  end

`ifdef PWM_DEADTIME_EN
  localparam logic [DEADTIME_WIDTH-1:0] DT_ZERO = {DEADTIME_WIDTH{1'b0}};
  localparam logic [DEADTIME_WIDTH-1:0] DT_ONE  = {{(DEADTIME_WIDTH-1){1'b0}}, 1'b1};

  logic                      level_q;
  logic                      level_q_next;
  logic [DEADTIME_WIDTH-1:0] dt_count;
  logic [DEADTIME_WIDTH-1:0] dt_count_next;
  logic                      gap;

  // Dead-time sequencing. Each level edge blanks both outputs for dead_time cycles.
  always_comb begin
    level_q_next  = level_q;
    dt_count_next = dt_count;
    gap           = 1'b0;
    if (!enable) begin
      level_q_next  = 1'b0;
      dt_count_next = DT_ZERO;
      gap           = 1'b0;
    end else if (level != level_q) begin
      // A fresh edge always restarts the gap, even if one is in progress.
      // This cycle's blanked output is the first of the dead_time cycles,
      // so the counter holds only the cycles that remain after it.
      level_q_next = level;
      if (dead_time != DT_ZERO) begin
        gap           = 1'b1;
        dt_count_next = dead_time - DT_ONE;
      end else begin
        gap           = 1'b0;
        dt_count_next = DT_ZERO;
      end
    end else if (dt_count != DT_ZERO) begin
      gap           = 1'b1;
      dt_count_next = dt_count - DT_ONE;
    end else begin
      gap           = 1'b0;
      dt_count_next = DT_ZERO;
    end

    if (!enable || gap) begin
      out_next   = active_polarity;
      out_n_next = active_polarity;
    end else begin
      out_next   = level ^ active_polarity;
      out_n_next = (~level) ^ active_polarity;
    end
  end

  // Dead-time state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      level_q  <= 1'b0;
      dt_count <= DT_ZERO;
    end else begin
      level_q  <= level_q_next;
      dt_count <= dt_count_next;
    end
  end
`else
  logic unused_dead_time;
  assign unused_dead_time = ^dead_time;

  // Polarity and idle level. The complement follows pwm_out with no gap.
  always_comb begin
    if (enable) begin
      out_next = level ^ active_polarity;
    end else begin
      out_next = active_polarity;
    end
    out_n_next = ~out_next;
  end
`endif

  // Registered outputs, one clk after counter_value.
  always_ff @(posedge clk) begin
    if (rst) begin
      pwm_out      <= 1'b0;
      pwm_out_n    <= 1'b0;
      match_pulse  <= 1'b0;
      period_pulse <= 1'b0;
    end else begin
      pwm_out      <= out_next;
      pwm_out_n    <= out_n_next;
      match_pulse  <= match_now;
      period_pulse <= period_start;
    end
  end

endmodule

// File: doc/pwm_compare_channel.md
Name: pwm_compare_channel

Overview:
- Downstream consumer of the shared free-running Counter value. Turns that value into one PWM output channel.
- Compare value and polarity are double-buffered: a shadow register takes CPU/wishbone writes, and the active register loads only at a period boundary, so the output never glitches mid-period.
- Emits single-cycle match and period-start strobes for the interrupt/status logic.

Parameters:
- WIDTH, 8, width of counter_value and the compare registers; must equal the feeding Counter WIDTH.
- DEADTIME_WIDTH, 4, width of the dead-time counter. Used only with PWM_DEADTIME_EN.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous reset, active-high.
- enable  input  1  channel enable; 0 forces idle level.
- counter_value  input  WIDTH  registered value from the upstream Counter (up or down).
- cfg_write  input  1  one-cycle strobe; captures cfg_compare and cfg_polarity.
- cfg_compare  input  WIDTH  new compare (duty) value.
- cfg_polarity  input  1  0 = active-high output, 1 = active-low output.
- dead_time  input  DEADTIME_WIDTH  dead-time cycles; ignored without the macro.
- pwm_out  output  1  PWM output.
- pwm_out_n  output  1  complementary output.
- match_pulse  output  1  one-cycle strobe when the counter reaches the active compare value.
- period_pulse  output  1  one-cycle strobe at each period boundary.
- update_pending  output  1  shadow holds a value not yet applied.

Behaviour:
- Reset values:
  - pwm_out, pwm_out_n, match_pulse, period_pulse, update_pending all 0.
  - shadow/active compare 0, shadow/active polarity 0, prev_value 0, prev_valid 0.
- prev_value/prev_valid:
  - Every cycle, prev_value <= counter_value.
  - prev_valid <= enable; cleared when enable=0.
- Period boundary: period_start = enable & (counter_value==0) & (!prev_valid | prev_value!=0).
  - A halted counter sitting at 0 yields exactly one boundary.
- Writes:
  - cfg_write with enable=1: shadow <= {cfg_compare, cfg_polarity}, update_pending <= 1.
  - cfg_write with enable=0: shadow and active both load directly; update_pending <= 0.
- Active load: at period_start with update_pending=1, active <= shadow and update_pending <= 0.
- Simultaneous cfg_write and period_start (enable=1): active loads the OLD shadow, the new write lands in shadow, update_pending stays 1.
- Level and output:
  - Raw level: level = (counter_value < active_compare), unsigned compare, full WIDTH.
  - pwm_out <= enable ? level ^ active_polarity : active_polarity, i.e. idle = inactive level.
  - Output latency: 1 clk after counter_value.
- Duty edge cases:
  - compare 0 gives a constantly inactive output.
  - With a full-range counter, maximum duty is (2^WIDTH-1)/2^WIDTH.
  - A compare above the counter's TOP gives a constantly active output.
- Strobes:
  - match_pulse <= enable & (counter_value==active_compare) & (!prev_valid | prev_value!=counter_value); no repeats while the counter is halted.
  - period_pulse <= period_start, registered, same cycle as the pwm_out update.
- enable deassert mid-period: next cycle pwm_out goes to idle, no strobes; shadow/pending retained.
- rst mid-period: all state returns to reset values next cycle regardless of enable/cfg_write.
- Counting direction: works for up and down counters; the boundary is defined solely by the transition into 0.

Optional Feature:
- Macro: PWM_DEADTIME_EN.
- With macro defined:
  - pwm_out_n is the complementary level.
  - On every change of the internal (pre-polarity) level, both outputs go inactive for dead_time clk cycles, driven by a DEADTIME_WIDTH down-counter; the new side then asserts.
  - dead_time 0 means no gap.
  - If the level toggles back during the gap, the counter reloads from the new edge.
  - enable=0 or rst clears the counter; both outputs go idle.
- Without macro: no dead-time counter; dead_time ignored; pwm_out_n is the registered inverse of pwm_out.

Test Plan:
- Enable=0, write compare=64, then enable with an up counter 0..255 → pwm_out high for counter 0..63 (one clk late), low 64..255; match_pulse once per period at 64; period_pulse at each 0.
- Running at compare=64, write 192 when counter=100 → update_pending=1, duty unchanged until next counter=0, then high for 0..191, pending=0.
- cfg_write of compare=10 in the same cycle as the counter entering 0 → active loads the prior shadow, pending stays 1, 10 applied at the following boundary.
- Counter halted at 0 for 5 cycles, then compare=0 and compare=200 with TOP=100 → one period_pulse only; compare=0 always low; compare=200 always high.
- cfg_polarity=1 with compare=64, then deassert enable mid-period → inverted waveform; pwm_out=1 (idle) the cycle after enable falls; rst mid-period → all outputs 0.
- With PWM_DEADTIME_EN, dead_time=3, compare=64 → at each level change both outputs inactive for exactly 3 clks; dead_time=0 → strict complements.
